// File: rtl/dtcm_ahb_slave_pkg.sv
// Shared AHB codes, DTCM map and FSM state type for the DTCM AHB-Lite slave.
package dtcm_ahb_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [31:0] DTCM_BASE = 32'h2000_0000;
    localparam logic [31:0] DTCM_SIZE = 32'h0001_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_WR_STALL,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Sizes other than byte/half behave as word.
    function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            HSIZE_BYTE: bad = 1'b0;
            HSIZE_HALF: bad = addr_lo[0];
            default:    bad = |addr_lo;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dtcm_ahb_slave_if.sv
// AHB-Lite bus bundle between the LSU d_* master and the DTCM slave.
interface dtcm_ahb_slave_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready_in;
    logic [31:0] hrdata;
    logic        hready_out;
    logic [1:0]  hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready_in,
        input  hrdata, hready_out, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready_in,
        output hrdata, hready_out, hresp
    );
endinterface

// File: rtl/dtcm_sram_sp.sv
// Single-port synchronous SRAM, 2**AW x 32, per-byte write enables, 1-cycle read.
module dtcm_sram_sp #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          re,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    // NOTE: storage and read register carry no reset; a RAM macro cannot be cleared in one cycle and contents must survive rst_n.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/dtcm_ahb_slave.sv
// AHB-Lite slave for the 64 KB DTCM: FSM, address/byte-enable registers and output muxing.
// Optional alignment check enabled by defining DTCM_ALIGN_CHK_EN.
module dtcm_ahb_slave
    import dtcm_ahb_slave_pkg::*;
#(
    parameter int AW        = 14,
    parameter bit INIT_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    dtcm_ahb_slave_if.slave   bus
);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [3:0]    be_q;

    logic          addr_phase, rd_conflict, hready_int, acc, bad_align, sram_re;
    logic [AW-1:0] sram_addr;
    logic [3:0]    sram_we;
    logic [31:0]   sram_q;

    assign addr_phase  = bus.hsel && bus.htrans[1];
    // A read cannot share the SRAM port with the write completing this cycle.
    assign rd_conflict = (state_q == ST_WR_DATA) && addr_phase && !bus.hwrite;
    assign hready_int  = !(rd_conflict || (state_q == ST_ERR1));
    assign acc         = addr_phase && bus.hready_in && hready_int;

`ifdef DTCM_ALIGN_CHK_EN
    assign bad_align = misaligned(bus.hsize, bus.haddr[1:0]);
`else
    assign bad_align = 1'b0;
`endif

    // NOTE: every output gets a default before the case so no path leaves a latch.
    always_comb begin
        state_d = ST_IDLE;
        sram_re = 1'b0;
        case (state_q)
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                if (rd_conflict) begin
                    state_d = ST_WR_STALL;
                end else if (acc) begin
                    if (bad_align) begin
                        state_d = ST_ERR1;
                    end else if (bus.hwrite) begin
                        state_d = ST_WR_DATA;
                    end else begin
                        state_d = ST_RD_DATA;
                        sram_re = 1'b1;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            if (acc) begin
                addr_q <= bus.haddr[AW+1:2];
                be_q   <= byte_enable(bus.hsize, bus.haddr[1:0]);
            end
        end
    end

    assign sram_addr = (state_q == ST_WR_DATA) ? addr_q : bus.haddr[AW+1:2];
    assign sram_we   = (state_q == ST_WR_DATA) ? be_q : 4'b0000;

    dtcm_sram_sp #(.AW(AW)) u_sram (
        .clk   (clk),
        .addr  (sram_addr),
        .re    (sram_re),
        .we    (sram_we),
        .wdata (bus.hwdata),
        .rdata (sram_q)
    );

    assign bus.hrdata     = (state_q == ST_RD_DATA) ? sram_q : 32'h0;
    assign bus.hready_out = hready_int;
    assign bus.hresp      = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

    // Zero-fill is a simulator memory-initialisation option; burst, protection and upper address bits are don't-care.
    logic unused_bits;
    assign unused_bits = ^{INIT_ZERO, bus.htrans[0], bus.hburst, bus.hprot, bus.haddr[31:AW+2]};

endmodule

// File: tb/tb_dtcm_ahb_slave.sv
// Self-checking bench for dtcm_ahb_slave: reference memory model plus in-order response scoreboard.
module tb_dtcm_ahb_slave;
    import dtcm_ahb_slave_pkg::*;

    localparam int AW = 14;

    typedef struct {
        logic        is_read;
        logic        err;
        logic [31:0] data;
    } sb_entry_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dtcm_ahb_slave_if bus ();
    assign bus.hready_in = bus.hready_out;

    dtcm_ahb_slave #(.AW(AW), .INIT_ZERO(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int err_low_cycles = 0;
    sb_entry_t sb_q[$];
    logic [31:0] mem_model [int unsigned];
    logic dp_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] addr);
        return int'(addr[AW+1:2]);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        if (mem_model.exists(widx(addr))) return mem_model[widx(addr)];
        return 32'h0;
    endfunction

    function automatic logic exp_err(input logic [2:0] size, input logic [31:0] addr);
`ifdef DTCM_ALIGN_CHK_EN
        if (size == 3'b001) return addr[0];
        if (size != 3'b000) return addr[1:0] != 2'b00;
`endif
        return 1'b0;
    endfunction

    function automatic void model_write(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        logic [3:0]  lanes;
        logic [31:0] w;
        if (size == 3'b000)      lanes = 4'b0001 << addr[1:0];
        else if (size == 3'b001) lanes = addr[1] ? 4'b1100 : 4'b0011;
        else                     lanes = 4'b1111;
        w = model_read(addr);
        for (int b = 0; b < 4; b++) if (lanes[b]) w[8*b +: 8] = wdata[8*b +: 8];
        mem_model[widx(addr)] = w;
    endfunction

    task automatic ahb_idle(input int n);
        bus.hsel   = 1'b0;
        bus.htrans = HTRANS_IDLE;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that accepts the address phase.
    task automatic ahb_xfer(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, output int stalls);
        sb_entry_t e;
        bus.hsel   = 1'b1;
        bus.htrans = HTRANS_NONSEQ;
        bus.hwrite = wr;
        bus.hsize  = size;
        bus.haddr  = addr;
        e.is_read  = !wr;
        e.err      = exp_err(size, addr);
        e.data     = wr ? 32'h0 : model_read(addr);
        if (wr && !e.err) model_write(size, addr, wdata);
        sb_q.push_back(e);
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.hready_out) break;
            stalls++;
        end
        if (stalls >= 16) check("accept_timeout", 32'(stalls), 32'd0);
        @(posedge clk);
        #1;
        bus.hwdata = wr ? wdata : 32'h0;
    endtask

    // Response monitor: pops one scoreboard entry per completed data phase.
    always @(negedge clk) begin
        sb_entry_t e;
        if (!rst_n) begin
            if (dp_valid && sb_q.size() > 0) void'(sb_q.pop_front());
            dp_valid = 1'b0;
        end else begin
            if (dp_valid) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd0, 32'd1);
                end else if (!bus.hready_out) begin
                    if (sb_q[0].err) begin
                        err_low_cycles++;
                        check("err1_hresp", 32'(bus.hresp), 32'(HRESP_ERROR));
                    end
                end else begin
                    e = sb_q.pop_front();
                    check(e.is_read ? "rd_hresp" : "wr_hresp", 32'(bus.hresp),
                          e.err ? 32'(HRESP_ERROR) : 32'(HRESP_OKAY));
                    if (e.is_read) check(e.err ? "err_hrdata" : "rd_hrdata", bus.hrdata, e.data);
                end
            end
            if (bus.hready_out) dp_valid = bus.hsel && bus.htrans[1] && bus.hready_in;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;
        logic [31:0] saved;
        bus.hsel = 1'b0; bus.haddr = '0; bus.htrans = HTRANS_IDLE; bus.hwrite = 1'b0;
        bus.hsize = HSIZE_WORD; bus.hburst = 3'b000; bus.hprot = 4'b0011; bus.hwdata = '0;

        repeat (2) @(negedge clk);
        check("rst_hready", 32'(bus.hready_out), 32'd1);
        check("rst_hresp",  32'(bus.hresp), 32'(HRESP_OKAY));
        check("rst_hrdata", bus.hrdata, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: store then back-to-back load of the same word stalls exactly once
        ahb_xfer(1'b1, HSIZE_WORD, DTCM_BASE + 32'h10, 32'hDEAD_BEEF, st);
        ahb_xfer(1'b0, HSIZE_WORD, DTCM_BASE + 32'h10, 32'h0, st);
        check("raw_stall_cycles", 32'(st), 32'd1);
        ahb_idle(2);

        // 2: byte store into top lane, word and byte reads
        ahb_xfer(1'b1, HSIZE_WORD, DTCM_BASE + 32'h10, 32'h1122_3344, st);
        ahb_xfer(1'b1, HSIZE_BYTE, DTCM_BASE + 32'h13, 32'hAB00_0000, st);
        check("waw_stall_cycles", 32'(st), 32'd0);
        ahb_xfer(1'b0, HSIZE_WORD, DTCM_BASE + 32'h10, 32'h0, st);
        ahb_xfer(1'b0, HSIZE_BYTE, DTCM_BASE + 32'h13, 32'h0, st);
        ahb_idle(2);

        // 3: halfword store into upper half
        ahb_xfer(1'b1, HSIZE_WORD, DTCM_BASE, 32'hFFFF_FFFF, st);
        ahb_xfer(1'b1, HSIZE_HALF, DTCM_BASE + 32'h2, 32'h5566_0000, st);
        ahb_xfer(1'b0, HSIZE_WORD, DTCM_BASE, 32'h0, st);
        ahb_idle(2);

        // 4: ten consecutive loads with zero wait states
        for (int i = 0; i < 10; i++)
            ahb_xfer(1'b1, HSIZE_WORD, DTCM_BASE + 32'h100 + 32'(4*i), 32'hA5A5_0000 + 32'(i * 32'h111), st);
        ahb_idle(1);
        for (int i = 0; i < 10; i++) begin
            ahb_xfer(1'b0, HSIZE_WORD, DTCM_BASE + 32'h100 + 32'(4*i), 32'h0, st);
            check("rd_burst_stall", 32'(st), 32'd0);
        end
        // Address alias above the DTCM window
        ahb_xfer(1'b0, HSIZE_WORD, DTCM_BASE + DTCM_SIZE + 32'h104, 32'h0, st);
        ahb_idle(2);

        // 5: reset during the write data phase drops the write
        ahb_xfer(1'b1, HSIZE_WORD, DTCM_BASE + 32'h20, 32'hCAFE_F00D, st);
        ahb_idle(1);
        saved = model_read(DTCM_BASE + 32'h20);
        ahb_xfer(1'b1, HSIZE_WORD, DTCM_BASE + 32'h20, 32'h0000_0001, st);
        bus.hsel = 1'b0; bus.htrans = HTRANS_IDLE;
        rst_n = 1'b0;
        mem_model[widx(DTCM_BASE + 32'h20)] = saved;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_hready", 32'(bus.hready_out), 32'd1);
        check("post_rst_hresp",  32'(bus.hresp), 32'(HRESP_OKAY));
        ahb_xfer(1'b0, HSIZE_WORD, DTCM_BASE + 32'h20, 32'h0, st);
        ahb_idle(2);

        // 6: misaligned word load
        err_low_cycles = 0;
        ahb_xfer(1'b0, HSIZE_WORD, DTCM_BASE + 32'h2, 32'h0, st);
        ahb_idle(3);
`ifdef DTCM_ALIGN_CHK_EN
        check("err1_cycles", 32'(err_low_cycles), 32'd1);
`else
        check("no_err_cycles", 32'(err_low_cycles), 32'd0);
`endif

        // Random sub-word stores each followed by a word load
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, d;
            logic [2:0]  sz;
            a  = DTCM_BASE + 32'h200 + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
            d  = $urandom;
            sz = 3'($urandom_range(0, 2));
            ahb_xfer(1'b1, sz, a, d, st);
            ahb_xfer(1'b0, HSIZE_WORD, {a[31:2], 2'b00}, 32'h0, st);
        end
        ahb_idle(4);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
